fifo_wr_arb: RTL

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_arb_pkg.sv | 26 ++
 rtl/fifo_wr_arb_rr_pick.sv | 35 +++
 rtl/syn_fifo.sv | 49 ++++
 rtl/fifo_wr_arb.sv | 111 +++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write arbiter.
//   arb_state_e : arbiter FSM state (IDLE / GRANT)
//   id_width()  : bits needed to index NUM_REQ requesters
//   cnt_width() : bits needed to count 0..MAX_BURST accepted words
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic int id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    function automatic int cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

    // Widths for the default configuration (NUM_REQ=4, MAX_BURST=4).
    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_MAX_BURST = 4;
    localparam int DEF_ID_W      = $clog2(DEF_NUM_REQ);
    localparam int DEF_CNT_W     = $clog2(DEF_MAX_BURST + 1);

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker.
//   req     : request vector, one bit per requester
//   last_id : requester granted most recently
//   found   : at least one request bit is set
//   idx     : first set bit searching from last_id+1 upward, wrapping
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_id,
    output logic               found,
    output logic [ID_W-1:0]    idx
);

    always_comb begin
        int              cand;
        logic [ID_W-1:0] c_idx;
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        c_idx = '0;
        // Walk from the farthest candidate to the nearest so the nearest
        // match after last_id is the one that sticks.
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand  = (int'(last_id) + k) % NUM_REQ;
            c_idx = ID_W'(cand);
            if (req[c_idx]) begin
                found = 1'b1;
                idx   = c_idx;
            end
        end
    end

endmodule

// File: rtl/syn_fifo.sv
// Simple synchronous FIFO with show-ahead read data.
//   wr_en/din  : push when not full
//   rd_en/dout : dout is the head word; pop when rd_en and not empty
//   full/empty : registered-occupancy status flags
// DEPTH must be a power of two (pointers wrap naturally).
module syn_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_wr, do_rd;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter in front of a shared synchronous FIFO.
// A requester is granted for up to MAX_BURST words; the grant ends early
// when the requester drops valid. One IDLE cycle separates grants.
//   clk, rst          : clock, synchronous active-high reset
//   req_valid/data    : per-requester word and valid (word i at [i*DW +: DW])
//   req_ready         : per-requester accept strobe
//   fifo_full         : FIFO full flag (backpressure)
//   fifo_wr_en/data_in: FIFO write port
//   grant_valid/id    : current grant holder
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 3,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic                          grant_valid,
    output logic [id_width(NUM_REQ)-1:0]  grant_id
);

    localparam int ID_W  = id_width(NUM_REQ);
    localparam int CNT_W = cnt_width(MAX_BURST);

    arb_state_e      state_q, state_d;
    logic [ID_W-1:0] gid_q, gid_d;
    logic [ID_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_words;
    logic            pick_found;
    logic [ID_W-1:0] pick_idx;
    logic            cur_valid;
    logic            xfer;

    assign req_words = req_data;
    assign grant_id  = gid_q;
    assign cur_valid = req_valid[gid_q];
    assign xfer      = (state_q == GRANT) && cur_valid && !fifo_full;
    assign cnt_inc   = cnt_q + CNT_W'(1);

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req     (req_valid),
        .last_id (last_q),
        .found   (pick_found),
        .idx     (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gid_q   <= '0;
            last_q  <= ID_W'(NUM_REQ - 1);  // requester 0 wins first
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gid_q   <= gid_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        gid_d        = gid_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_data_in = '0;
        grant_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    gid_d   = pick_idx;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                grant_valid      = 1'b1;
                req_ready[gid_q] = !fifo_full;
                fifo_data_in     = req_words[gid_q];
                fifo_wr_en       = xfer;
                if (!cur_valid) begin
                    state_d = IDLE;
                    last_d  = gid_q;
                end else if (xfer) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(MAX_BURST)) begin
                        state_d = IDLE;
                        last_d  = gid_q;
                    end
                end
                // fifo_full with valid held: stall, nothing changes
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
